// File: rtl/dma_dev_port_pkg.sv
// Shared definitions for the DMA device-side bridge.
// Holds the bridge FSM state encoding and the transfer direction constants.
package dma_dev_port_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StXfer  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic RD = 1'b1;  // memory -> device
  localparam logic WR = 1'b0;  // device -> memory

endpackage

// File: rtl/dma_dev_skid.sv
// Two-entry skid FIFO for read-direction data heading to the peripheral.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write side (ignored while full)
//   pop                 read side (ignored while empty)
//   pop_data            head entry, registered storage
//   full, empty         occupancy flags
module dma_dev_skid #(
  parameter int unsigned DATA_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [DATA_LEN-1:0] pop_data,
  output logic                full,
  output logic                empty
);

  logic [DATA_LEN-1:0] mem_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q;
  logic                do_push, do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dma_dev_port.sv
// Device-side bridge for the DMA controller.
// Accepts one transfer command, pulses rqst to the controller, then runs the
// dev_ack/dma_ack word handshake, exposing it as a valid/ready source stream
// (write direction) or sink stream (read direction, via a 2-entry skid FIFO).
// Reports completion (done), short transfers (err_short) and timeouts (err_tmo).
// Optional feature: define DMA_DEV_TIMEOUT_EN to enable the stall timeout;
// otherwise err_tmo is tied 0 and the block waits indefinitely.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_addr,
//   cmd_len, cmd_rd                    peripheral command
//   src_data/src_valid/src_ready       write-direction stream in
//   snk_data/snk_valid/snk_ready       read-direction stream out
//   num_words, start_addr, rd_wr, rqst controller command
//   dev_ack, dev_in                    controller data handshake (to ctrl)
//   dma_ack, dev_out, end_flag         controller responses
//   done, err_short, err_tmo, xfer_cnt status
module dma_dev_port
  import dma_dev_port_pkg::*;
#(
  parameter int unsigned ADD_LEN  = 16,
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned TMO_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic [ADD_LEN-1:0]  cmd_len,
  input  logic                cmd_rd,
  input  logic [DATA_LEN-1:0] src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [DATA_LEN-1:0] snk_data,
  output logic                snk_valid,
  input  logic                snk_ready,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                rd_wr,
  output logic                rqst,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag,
  output logic                done,
  output logic                err_short,
  output logic                err_tmo,
  output logic [ADD_LEN-1:0]  xfer_cnt
);

  state_e              state_q, state_d;
  logic [ADD_LEN:0]    addr_q;
  logic [ADD_LEN-1:0]  len_q;
  logic                rd_q;
  logic [ADD_LEN-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                err_short_q, err_short_d;
  logic                cmd_load;
  logic                in_xfer;
  logic                xfer_hs;
  logic                tmo_hit;
  logic                skid_full, skid_empty;

  assign start_addr = addr_q;
  assign num_words  = len_q;
  assign rd_wr      = rd_q;
  assign xfer_cnt   = xfer_cnt_q;
  assign err_short  = err_short_q;

  // Handshake decode kept outside the FSM process so the timeout logic can
  // observe it without forming a combinational loop through the FSM.
  assign in_xfer   = (state_q == StXfer);
  assign dev_ack   = in_xfer && ((rd_q == RD) ? !skid_full : src_valid);
  assign xfer_hs   = dev_ack && dma_ack;
  assign dev_in    = (in_xfer && (rd_q == WR)) ? src_data : '0;
  assign src_ready = in_xfer && (rd_q == WR) && dma_ack;
  assign snk_valid = !skid_empty;

  dma_dev_skid #(
    .DATA_LEN (DATA_LEN)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (xfer_hs && (rd_q == RD)),
    .push_data (dev_out),
    .pop       (snk_ready),
    .pop_data  (snk_data),
    .full      (skid_full),
    .empty     (skid_empty)
  );

`ifdef DMA_DEV_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_tmo_q;

  // Counts stalled cycles (dev_ack without dma_ack); any progress restarts it.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q == StReq || state_q == StXfer) begin
      tmo_d = tmo_q;
      if (xfer_hs || end_flag) begin
        tmo_d = '0;
      end else if (dev_ack && !dma_ack) begin
        tmo_d   = tmo_q + 1'b1;
        tmo_hit = (tmo_d == '1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (cmd_load) begin
        err_tmo_q <= 1'b0;
      end else if (tmo_hit) begin
        err_tmo_q <= 1'b1;
      end
    end
  end

  assign err_tmo = err_tmo_q;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
  assign err_tmo    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rqst        = 1'b0;
    done        = 1'b0;
    cmd_load    = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;
    err_short_d = err_short_q;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_load    = 1'b1;
          xfer_cnt_d  = '0;
          err_short_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        rqst    = 1'b1;
        state_d = end_flag ? StDrain : StXfer;
      end
      StXfer: begin
        // A word arriving with end_flag is counted before the DRAIN check.
        if (xfer_hs && (xfer_cnt_q != '1)) begin
          xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
        if (end_flag || tmo_hit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (skid_empty) begin
          if (xfer_cnt_q != len_q) begin
            err_short_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      rd_q        <= WR;
      xfer_cnt_q  <= '0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_short_q <= err_short_d;
      if (cmd_load) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        rd_q   <= cmd_rd;
      end
    end
  end

endmodule

// File: tb/tb_dma_dev_port.sv
// Scoreboard bench for dma_dev_port: stimulus pushes expected commands, data
// words and completion records; a monitor pops and compares them whenever the
// DUT presents rqst, a write handshake, a sink handshake or done.
module tb_dma_dev_port;

  localparam int AL = 16;
  localparam int DL = 16;
`ifdef DMA_DEV_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_rd;
  logic [AL:0]   cmd_addr;
  logic [AL-1:0] cmd_len;
  logic [DL-1:0] src_data, snk_data, dev_in, dev_out;
  logic          src_valid, src_ready, snk_valid, snk_ready;
  logic [AL-1:0] num_words, xfer_cnt;
  logic [AL:0]   start_addr;
  logic          rd_wr, rqst, dev_ack, dma_ack, end_flag, done, err_short, err_tmo;

  dma_dev_port #(
    .ADD_LEN  (AL),
    .DATA_LEN (DL),
    .TMO_W    (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_rd     (cmd_rd),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .snk_data   (snk_data),
    .snk_valid  (snk_valid),
    .snk_ready  (snk_ready),
    .num_words  (num_words),
    .start_addr (start_addr),
    .rd_wr      (rd_wr),
    .rqst       (rqst),
    .dev_ack    (dev_ack),
    .dev_in     (dev_in),
    .dma_ack    (dma_ack),
    .dev_out    (dev_out),
    .end_flag   (end_flag),
    .done       (done),
    .err_short  (err_short),
    .err_tmo    (err_tmo),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AL:0]   addr;
    logic [AL-1:0] len;
    logic          rd;
  } cmd_t;

  typedef struct packed {
    logic [AL-1:0] cnt;
    logic          short_err;
    logic          tmo_err;
  } done_t;

  cmd_t          cmd_q[$];
  done_t         done_q[$];
  logic [DL-1:0] wr_q[$];
  logic [DL-1:0] rd_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int snk_mode = 3;  // 0 random, 1 toggle, 2 hold low, 3 hold high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Sink-side peripheral.
  initial begin
    snk_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (snk_mode)
        0:       snk_ready = 1'($urandom % 2);
        1:       snk_ready = !snk_ready;
        2:       snk_ready = 1'b0;
        default: snk_ready = 1'b1;
      endcase
    end
  end

  // Monitor: samples mid-cycle, after all inputs for this cycle are settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (rqst) begin
          check("rqst_expected", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0) begin
            cmd_t c;
            c = cmd_q.pop_front();
            check("start_addr", 32'(start_addr), 32'(c.addr));
            check("num_words", 32'(num_words), 32'(c.len));
            check("rd_wr", 32'(rd_wr), 32'(c.rd));
          end
        end
        if (dev_ack && dma_ack && !rd_wr) begin
          check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
          check("src_ready", 32'(src_ready), 32'd1);
          if (wr_q.size() != 0) check("dev_in", 32'(dev_in), 32'(wr_q.pop_front()));
        end
        if (snk_valid && snk_ready) begin
          check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) check("snk_data", 32'(snk_data), 32'(rd_q.pop_front()));
        end
        if (done) begin
          check("done_expected", 32'(done_q.size() != 0), 32'd1);
          check("rd_drained_before_done", 32'(rd_q.size()), 32'd0);
          if (done_q.size() != 0) begin
            done_t d;
            d = done_q.pop_front();
            check("xfer_cnt", 32'(xfer_cnt), 32'(d.cnt));
            check("err_short", 32'(err_short), 32'(d.short_err));
            check("err_tmo", 32'(err_tmo), 32'(d.tmo_err));
          end
        end
      end
    end
  end

  task automatic issue_cmd(input logic [AL:0] addr, input logic [AL-1:0] len, input logic rd);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_rd    = rd;
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    // Scramble the bus; latched command must not follow it.
    cmd_valid = 1'b0;
    cmd_addr  = (AL+1)'($urandom);
    cmd_len   = AL'($urandom);
    cmd_rd    = 1'($urandom % 2);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((done_q.size() != 0 || rd_q.size() != 0 || cmd_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 32'(done_q.size() + rd_q.size() + cmd_q.size()), 32'd0);
    done_q.delete();
    rd_q.delete();
    cmd_q.delete();
    wr_q.delete();
    @(negedge clk);
  endtask

  // pat: 0 random words, 1 0xA001+i, 2 0x1111*(i+1). src_always: hold src_valid.
  task automatic run_xfer(input logic [AL:0] addr, input int len, input logic rd,
                          input int nmove, input int pat, input bit src_always);
    logic [DL-1:0] words[$];
    cmd_t  c;
    done_t d;
    int    cnt, guard;
    bit    fin, hs;
    for (int i = 0; i < nmove; i++) begin
      logic [DL-1:0] w;
      if (pat == 1) w = DL'(16'hA001 + i);
      else if (pat == 2) w = DL'(16'h1111 * (i + 1));
      else w = DL'($urandom);
      words.push_back(w);
      if (rd) rd_q.push_back(w);
      else wr_q.push_back(w);
    end
    c.addr = addr;
    c.len  = AL'(len);
    c.rd   = rd;
    cmd_q.push_back(c);
    d.cnt       = AL'(nmove);
    d.short_err = (nmove != len);
    d.tmo_err   = 1'b0;
    done_q.push_back(d);
    issue_cmd(addr, AL'(len), rd);
    // Controller model: acks nmove words, then raises end_flag.
    cnt   = 0;
    guard = 0;
    fin   = 1'b0;
    while (!fin && guard < 2000) begin
      dma_ack   = (cnt < nmove) ? (($urandom % 4) != 0) : 1'b0;
      src_valid = rd ? 1'b0 : (src_always ? 1'b1 : 1'($urandom % 2));
      src_data  = (!rd && cnt < nmove) ? words[cnt] : DL'($urandom);
      dev_out   = (rd && cnt < nmove) ? words[cnt] : DL'($urandom);
      end_flag  = 1'b0;
      #1;
      hs = dev_ack && dma_ack;
      if (hs) cnt++;
      if (cnt == nmove && (!hs || ($urandom % 2) == 1)) end_flag = 1'b1;
      fin = end_flag;
      @(negedge clk);
      guard++;
    end
    end_flag  = 1'b0;
    dma_ack   = 1'b0;
    src_valid = 1'b0;
    check("ctrl_finished", 32'(fin), 32'd1);
    wait_idle(300);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_rd    = 1'b0;
    src_data  = '0;
    src_valid = 1'b0;
    dev_out   = '0;
    dma_ack   = 1'b0;
    end_flag  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rqst", 32'(rqst), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dev_ack", 32'(dev_ack), 32'd0);
    check("rst_snk_valid", 32'(snk_valid), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_errs", 32'({err_short, err_tmo}), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_cmd_regs", 32'({start_addr, num_words, rd_wr}), 32'd0);
    reset = 1'b0;

    // Directed cases.
    snk_mode = 3;
    run_xfer(17'h00200, 4, 1'b0, 4, 1, 1'b1);
    snk_mode = 1;
    run_xfer(17'h00100, 3, 1'b1, 3, 2, 1'b0);
    snk_mode = 0;
    run_xfer(17'h00300, 5, 1'b0, 2, 0, 1'b0);
    run_xfer(17'h00400, 5, 1'b1, 2, 0, 1'b0);
    run_xfer(17'h00500, 0, 1'b0, 0, 0, 1'b0);
    run_xfer(17'h00600, 0, 1'b1, 0, 0, 1'b0);

    // Reset with two words held in the skid buffer.
    begin
      cmd_t c;
      int   n;
      snk_mode = 2;
      c.addr = 17'h00700;
      c.len  = 16'd5;
      c.rd   = 1'b1;
      cmd_q.push_back(c);
      issue_cmd(c.addr, c.len, c.rd);
      n = 0;
      for (int g = 0; g < 20; g++) begin
        dma_ack = 1'b1;
        dev_out = DL'($urandom);
        #1;
        if (dev_ack) n++;
        else if (n >= 2) break;
        @(negedge clk);
      end
      check("skid_words_before_reset", 32'(n), 32'd2);
      check("snk_valid_before_reset", 32'(snk_valid), 32'd1);
      reset   = 1'b1;
      dma_ack = 1'b0;
      #1;
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_snk_valid", 32'(snk_valid), 32'd0);
      check("mid_rst_dev_ack", 32'(dev_ack), 32'd0);
      check("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cmd_q.delete();
      @(negedge clk);
      check("post_rst_snk_valid", 32'(snk_valid), 32'd0);
    end

`ifdef DMA_DEV_TIMEOUT_EN
    // Stall: dev_ack held high, controller never acks.
    begin
      cmd_t  c;
      done_t d;
      snk_mode = 3;
      c.addr = 17'h00800;
      c.len  = 16'd3;
      c.rd   = 1'b0;
      cmd_q.push_back(c);
      d.cnt       = '0;
      d.short_err = 1'b1;
      d.tmo_err   = 1'b1;
      done_q.push_back(d);
      issue_cmd(c.addr, c.len, c.rd);
      src_valid = 1'b1;
      dma_ack   = 1'b0;
      wait_idle(60);
      src_valid = 1'b0;
      // Late controller traffic after the timeout must be ignored.
      dma_ack  = 1'b1;
      end_flag = 1'b1;
      #1;
      check("tmo_late_dev_ack", 32'(dev_ack), 32'd0);
      @(negedge clk);
      dma_ack  = 1'b0;
      end_flag = 1'b0;
      #1;
      check("tmo_idle_after", 32'(cmd_ready), 32'd1);
      check("tmo_err_sticky", 32'(err_tmo), 32'd1);
    end
`endif

    // Randomized transfers.
    for (int t = 0; t < 25; t++) begin
      int   len, nmove, m;
      logic rd;
      len   = $urandom_range(0, 8);
      nmove = (($urandom % 3) == 0) ? $urandom_range(0, len) : len;
      rd    = 1'($urandom % 2);
      m     = $urandom_range(0, 2);
      snk_mode = (m == 2) ? 3 : m;
      run_xfer((AL+1)'($urandom), len, rd, nmove, 0, 1'($urandom % 2));
    end
`ifdef DMA_DEV_TIMEOUT_EN
    check("tmo_cleared_by_cmd", 32'(err_tmo), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/dma_dev_port.md
# dma_dev_port

Device-side bridge for the DMA controller. It accepts one transfer command (address, word count, direction) from a peripheral, issues the controller request, and runs the word-level `dev_ack`/`dma_ack` handshake. It converts that handshake into valid/ready source and sink streams, and reports completion, short transfers and timeouts. It sits between a peripheral's data path and the DMA controller's device interface.

## Interface
- `ADD_LEN`, 16: word-address width; `start_addr` is `ADD_LEN+1` bits (byte address).
- `DATA_LEN`, 16: data word width.
- `TMO_W`, 8: timeout counter width (used only with the macro in Configuration).
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block in IDLE and able to accept a command.
- `cmd_addr`  in  ADD_LEN+1  byte start address.
- `cmd_len`  in  ADD_LEN  word count.
- `cmd_rd`  in  1  1 = memory→device (read), 0 = device→memory (write).
- `src_data`  in  DATA_LEN  write-direction data from the peripheral.
- `src_valid` in 1, `src_ready` out 1: write stream handshake.
- `snk_data` out DATA_LEN, `snk_valid` out 1, `snk_ready` in 1: read stream to the peripheral.
- `num_words` out ADD_LEN, `start_addr` out ADD_LEN+1, `rd_wr` out 1, `rqst` out 1: controller command.
- `dev_ack` out 1, `dev_in` out DATA_LEN: controller data handshake.
- `dma_ack` in 1, `dev_out` in DATA_LEN, `end_flag` in 1: controller responses.
- `done`  out  1  one-cycle completion pulse.
- `err_short`  out  1  sticky: `end_flag` arrived before `cmd_len` words moved; cleared by the next accepted command.
- `err_tmo`  out  1  sticky timeout flag; cleared by the next accepted command.
- `xfer_cnt`  out  ADD_LEN  words moved in the current or last transfer.

## Operation
- Command registers:
  - `cmd_valid && cmd_ready` latches the address, length and direction into registers that drive `start_addr`, `num_words` and `rd_wr`.
  - These registers stay stable until the next command is accepted.
- FSM states:
  - IDLE: `cmd_ready` = 1. An accepted command clears `xfer_cnt`, `err_short` and `err_tmo`, then goes to REQ.
  - REQ: `rqst` = 1 for exactly one cycle, then XFER.
  - XFER, write direction (`rd_wr` = 0): `dev_ack` = `src_valid`, `dev_in` = `src_data`, `src_ready` = `dma_ack`. A word transfers on each cycle with `dma_ack && dev_ack`; `xfer_cnt` increments by 1.
  - XFER, read direction (`rd_wr` = 1): `dev_ack` = skid buffer not full. On a cycle with `dma_ack && dev_ack`, `dev_out` is pushed into the skid buffer and `xfer_cnt` increments.
  - XFER exit: `end_flag` → DRAIN.
  - DRAIN: waits until the skid buffer is empty (immediate in the write direction). Sets `err_short` if `xfer_cnt` ≠ `num_words`. Goes to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE. This guarantees at least one idle cycle between `end_flag` and the next `rqst`.
- Zero-length command: still issued. The controller answers with `end_flag` and no data; the block ends with `xfer_cnt` = 0 and no error.
- `end_flag` in REQ is treated as in XFER: go to DRAIN.
- Simultaneous `dma_ack && dev_ack` and `end_flag`: the word counts before the DRAIN decision.
- `xfer_cnt` saturates at all-ones.
- `dma_ack` without `dev_ack`: ignored, no transfer, no count.

## Timing
- Reset values: all outputs 0 and FSM in IDLE, except `cmd_ready` = 1 (IDLE). Reset mid-transfer returns to IDLE at once and empties the skid buffer.
- Command acceptance to `rqst`: 1 cycle.
- Read path: data leaves `snk_data` no earlier than 1 cycle after capture. Throughput is 1 word/cycle while `snk_ready` is held high.
- Write path: zero latency from `src_valid` to `dev_ack`.
- `end_flag` (with empty buffer) → DRAIN → DONE: `done` occurs 2 cycles after `end_flag`.

## Configuration
- `DMA_DEV_TIMEOUT_EN`:
  - Defined: a `TMO_W`-bit counter runs in REQ/XFER. It resets on every transfer or `end_flag` and counts while `dev_ack` = 1 without `dma_ack`. On reaching all-ones it sets `err_tmo` and forces DRAIN then DONE; remaining controller traffic up to its `end_flag` is ignored in IDLE.
  - Undefined: no counter, `err_tmo` tied 0, and the block waits indefinitely.

## Structure
- Shared package holds:
  - FSM state encoding constants IDLE/REQ/XFER/DRAIN/DONE.
  - Direction constants (`RD` = 1, `WR` = 0).
- Sub-module `dma_dev_skid`: 2-entry, DATA_LEN-wide skid FIFO with `full`/`empty`. `full` drives `dev_ack` in the read direction, so backpressure is never combinational from `snk_ready`.

## Test plan
- Write of 4 words, addr 0x0200, src always valid, data 0xA001..0xA004: `num_words` = 4, `rd_wr` = 0, one `rqst` pulse, `dev_in` sequence matches, `xfer_cnt` = 4, `done` pulse, no errors.
- Read of 3 words, `snk_ready` toggling 1/0 every cycle: `snk_data` delivers 0x1111, 0x2222, 0x3333 in order with none lost or duplicated; `done` only after the last word is taken.
- `end_flag` after 2 of 5 words: `err_short` = 1, `xfer_cnt` = 2, `done` pulses.
- `cmd_len` = 0: `rqst` pulses, `end_flag` returns, `xfer_cnt` = 0, `done` pulses, no errors.
- Reset asserted mid-read with the buffer holding 2 words: next cycle IDLE, `snk_valid` = 0, `cmd_ready` = 1.
- With `DMA_DEV_TIMEOUT_EN` and `TMO_W` = 4: `dev_ack` high and no `dma_ack` for 15 cycles → `err_tmo` = 1, `done` pulses.
